// File: rtl/button_action_sequencer.sv
// rtl/button_action_sequencer.sv - grants one button request at a time to the game engine and acks it
// Define ACTION_RR_ARB_EN for round-robin arbitration; default is fixed lowest-index priority.
module button_action_sequencer #(
  parameter int N_BTN      = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       iReset,
  input  logic [N_BTN-1:0]           iReq,
  input  logic                       iEngineReady,
  input  logic                       iEngineDone,
  output logic                       oActionValid,
  output logic [$clog2(N_BTN)-1:0]   oActionId,
  output logic [N_BTN-1:0]           oAck,
  output logic                       oTimeout,
  output logic                       oBusy,
  output logic [4:0]                 LEDs
);

  localparam int IDW  = $clog2(N_BTN);
  localparam int MAXC = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT);
  localparam logic [CW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t         r_state, w_state_next;
  logic [IDW-1:0] r_grant, w_grant_next;
  logic [IDW-1:0] w_pick;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic           r_tmo, w_tmo_next;

`ifdef ACTION_RR_ARB_EN
  logic [IDW-1:0] r_last, w_last_next;

  // Descending scan so the candidate closest after r_last is assigned last and wins.
  always_comb begin
    int w_idx;
    w_pick = '0;
    w_idx  = 0;
    for (int k = N_BTN; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % N_BTN;
      if (iReq[w_idx[IDW-1:0]]) w_pick = w_idx[IDW-1:0];
    end
  end
`else
  always_comb begin
    w_pick = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (iReq[i[IDW-1:0]]) w_pick = i[IDW-1:0];
    end
  end
`endif

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
`ifdef ACTION_RR_ARB_EN
      r_last  <= IDW'(N_BTN - 1);
`endif
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_cnt   <= w_cnt_next;
      r_tmo   <= w_tmo_next;
`ifdef ACTION_RR_ARB_EN
      r_last  <= w_last_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_cnt_next   = r_cnt;
    w_tmo_next   = r_tmo;
`ifdef ACTION_RR_ARB_EN
    w_last_next  = r_last;
`endif
    case (r_state)
      S_IDLE: begin
        if (|iReq) begin
          w_grant_next = w_pick;
          w_tmo_next   = 1'b0;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A handshake in the same cycle as the request drop still proceeds.
        if (iEngineReady) begin
          w_cnt_next   = TMO_LOAD;
          w_state_next = S_WAIT;
        end else if (!iReq[r_grant]) begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (iEngineDone) begin
          w_tmo_next   = 1'b0;
          w_state_next = S_ACK;
        end else if (r_cnt == '0) begin
          w_tmo_next   = 1'b1;
          w_state_next = S_ACK;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_ACK: begin
        w_tmo_next = 1'b0;
`ifdef ACTION_RR_ARB_EN
        w_last_next = r_grant;
`endif
        if (GAP_CYCLES == 0) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next   = GAP_LOAD;
          w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    oActionValid = (r_state == S_ISSUE);
    oActionId    = '0;
    oAck         = '0;
    oTimeout     = 1'b0;
    oBusy        = (r_state != S_IDLE);
    LEDs         = 5'b00000;
    if (r_state == S_ISSUE) oActionId = r_grant;
    if (r_state == S_ACK) begin
      oAck[r_grant] = 1'b1;
      oTimeout      = r_tmo;
    end
    case (r_state)
      S_IDLE:  LEDs = 5'b00001;
      S_ISSUE: LEDs = 5'b00010;
      S_WAIT:  LEDs = 5'b00100;
      S_ACK:   LEDs = 5'b01000;
      S_GAP:   LEDs = 5'b10000;
      default: LEDs = 5'b00000;
    endcase
  end

endmodule
